micro_sequencer: RTL and testbench

- Programmable microcode sequencer that drives the control inputs of a datapath: register load enables and mux selects.
- It sits directly upstream of the datapath. Each state's control word is emitted on ctrl_out. The next state is chosen from a datapath condition bit, such as a condition-register output.
- It replaces a hard-coded state/next-state case table with a writable table, plus a start/done handshake and a run-length counter.

---
 rtl/micro_sequencer.sv | 148 ++++++++++++++
 tb/tb_micro_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/micro_sequencer.sv
// micro_sequencer: programmable microcode sequencer driving a datapath's control bus.
//
// A writable table holds one entry per state. Each entry gives the control word for
// that state, two successor states and the condition that picks between them, and a
// "last" flag that ends the run. A start/done handshake launches a run from
// ENTRY_STATE, and cycle_cnt counts the busy cycles of the current or most recent run.
//
// Entry layout, MSB to LSB:
//   last[1] | cond_en[1] | cond_sel[SEL_W] | next_t[STATE_W] | next_f[STATE_W] | ctrl[CTRL_W]
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset (table contents are kept)
//   start      in   launch the microprogram from ENTRY_STATE (ignored while busy)
//   busy       out  sequencer is running
//   done       out  one-cycle pulse after a last state completes
//   cond       in   datapath condition bits
//   ctrl_out   out  control word of the current state, zero while idle
//   state_out  out  current state index (debug)
//   cycle_cnt  out  busy cycles of the current or most recent run, saturating
//   prog_we    in   table write enable (ignored while busy)
//   prog_addr  in   table write address
//   prog_data  in   table write data
module micro_sequencer #(
  parameter int unsigned STATE_W     = 2,
  parameter int unsigned CTRL_W      = 2,
  parameter int unsigned COND_W      = 1,
  parameter int unsigned ENTRY_STATE = 0,
  parameter int unsigned CNT_W       = 16,
  localparam int unsigned SEL_W      = (COND_W > 1) ? $clog2(COND_W) : 1,
  localparam int unsigned ENTRY_W    = 2 + SEL_W + 2 * STATE_W + CTRL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  input  logic [COND_W-1:0]  cond,
  output logic [CTRL_W-1:0]  ctrl_out,
  output logic [STATE_W-1:0] state_out,
  output logic [CNT_W-1:0]   cycle_cnt,
  input  logic               prog_we,
  input  logic [STATE_W-1:0] prog_addr,
  input  logic [ENTRY_W-1:0] prog_data
);

  localparam int unsigned Depth = 2 ** STATE_W;

  typedef enum logic [0:0] {StIdle, StRun} mode_e;

  mode_e              mode_q, mode_d;
  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;

  logic [ENTRY_W-1:0] tbl_q [Depth];

  // Decoded fields of the current state's entry.
  logic [ENTRY_W-1:0] ent;
  logic               ent_last;
  logic               ent_cond_en;
  logic [SEL_W-1:0]   ent_sel;
  logic [STATE_W-1:0] ent_next_t;
  logic [STATE_W-1:0] ent_next_f;
  logic [CTRL_W-1:0]  ent_ctrl;
  logic               cond_bit;
  logic               tbl_we;

  assign ent         = tbl_q[state_q];
  assign ent_last    = ent[ENTRY_W-1];
  assign ent_cond_en = ent[ENTRY_W-2];
  assign ent_sel     = ent[CTRL_W + 2 * STATE_W +: SEL_W];
  assign ent_next_t  = ent[CTRL_W + STATE_W +: STATE_W];
  assign ent_next_f  = ent[CTRL_W +: STATE_W];
  assign ent_ctrl    = ent[CTRL_W-1:0];

  // The table only changes while idle, so a run always sees a stable program.
  assign tbl_we = prog_we && (mode_q == StIdle);

  // Out-of-range selects fall back to cond[0].
  always_comb begin
    cond_bit = cond[0];
    for (int i = 0; i < COND_W; i++) begin
      if (ent_sel == SEL_W'(i)) begin
        cond_bit = cond[i];
      end
    end
  end

  always_comb begin
    mode_d  = mode_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (mode_q)
      StIdle: begin
        if (start) begin
          mode_d  = StRun;
          state_d = STATE_W'(ENTRY_STATE);
          cnt_d   = '0;
        end
      end
      StRun: begin
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (ent_last) begin
          mode_d  = StIdle;
          done_d  = 1'b1;
          state_d = '0;
        end else if (ent_cond_en) begin
          state_d = cond_bit ? ent_next_t : ent_next_f;
        end else begin
          state_d = ent_next_t;
        end
      end
      default: mode_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= StIdle;
      state_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Table storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (tbl_we) begin
      tbl_q[prog_addr] <= prog_data;
    end
  end

  assign busy      = (mode_q == StRun);
  assign done      = done_q;
  assign ctrl_out  = busy ? ent_ctrl : '0;
  assign state_out = state_q;
  assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_micro_sequencer.sv
module tb_micro_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic [0:0]  cond;
  logic [1:0]  ctrl_out;
  logic [1:0]  state_out;
  logic [15:0] cycle_cnt;
  logic        prog_we;
  logic [1:0]  prog_addr;
  logic [8:0]  prog_data;

  micro_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .cond      (cond),
    .ctrl_out  (ctrl_out),
    .state_out (state_out),
    .cycle_cnt (cycle_cnt),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic [1:0]  ctrl;
    logic [1:0]  state;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Entries: {last, cond_en, cond_sel, next_t, next_f, ctrl}
  localparam logic [8:0] E0Cond  = {1'b0, 1'b1, 1'b0, 2'd2, 2'd1, 2'b11};
  localparam logic [8:0] E1Last  = {1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'b10};
  localparam logic [8:0] E2Last  = {1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'b11};
  localparam logic [8:0] E1Alt   = {1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'b01};
  localparam logic [8:0] E0Last  = {1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'b00};
  localparam logic [8:0] E0Loop  = {1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'b01};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Push what the DUT must show just after the next clock edge.
  task automatic expect_next(input logic b, input logic d, input logic [1:0] c,
                             input logic [1:0] s, input logic [15:0] n);
    exp_t e;
    e.busy  = b;
    e.done  = d;
    e.ctrl  = c;
    e.state = s;
    e.cnt   = n;
    exp_q.push_back(e);
  endtask

  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq({tag, ".busy"},  {31'd0, busy},      {31'd0, e.busy});
      check_eq({tag, ".done"},  {31'd0, done},      {31'd0, e.done});
      check_eq({tag, ".ctrl"},  {30'd0, ctrl_out},  {30'd0, e.ctrl});
      check_eq({tag, ".state"}, {30'd0, state_out}, {30'd0, e.state});
      check_eq({tag, ".cnt"},   {16'd0, cycle_cnt}, {16'd0, e.cnt});
      check_eq({tag, ".excl"},  {31'd0, busy & done}, 32'd0);
    end
  endtask

  task automatic prog(input logic [1:0] addr, input logic [8:0] data, input logic [15:0] cnt);
    prog_we   = 1'b1;
    prog_addr = addr;
    prog_data = data;
    expect_next(1'b0, 1'b0, 2'b00, 2'd0, cnt);
    tick("prog");
    prog_we = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    cond      = 1'b0;
    prog_we   = 1'b0;
    prog_addr = '0;
    prog_data = '0;

    expect_next(1'b0, 1'b0, 2'b00, 2'd0, 16'd0);
    tick("reset");
    rst = 1'b0;

    prog(2'd0, E0Cond, 16'd0);
    prog(2'd1, E1Last, 16'd0);
    prog(2'd2, E2Last, 16'd0);

    // cond=0: 11 -> 10 -> done.
    cond  = 1'b0;
    start = 1'b1;
    expect_next(1'b1, 1'b0, 2'b11, 2'd0, 16'd0);
    tick("c0.s0");
    start = 1'b0;
    expect_next(1'b1, 1'b0, 2'b10, 2'd1, 16'd1);
    tick("c0.s1");
    expect_next(1'b0, 1'b1, 2'b00, 2'd0, 16'd2);
    tick("c0.done");
    expect_next(1'b0, 1'b0, 2'b00, 2'd0, 16'd2);
    tick("c0.idle");

    // cond=1: 11 -> 11 (state 2) -> done.
    cond  = 1'b1;
    start = 1'b1;
    expect_next(1'b1, 1'b0, 2'b11, 2'd0, 16'd0);
    tick("c1.s0");
    start = 1'b0;
    expect_next(1'b1, 1'b0, 2'b11, 2'd2, 16'd1);
    tick("c1.s2");
    expect_next(1'b0, 1'b1, 2'b00, 2'd0, 16'd2);
    tick("c1.done");
    expect_next(1'b0, 1'b0, 2'b00, 2'd0, 16'd2);
    tick("c1.idle");

    // Reset mid-run: no done pulse afterwards.
    cond  = 1'b0;
    start = 1'b1;
    expect_next(1'b1, 1'b0, 2'b11, 2'd0, 16'd0);
    tick("rr.s0");
    start = 1'b0;
    rst   = 1'b1;
    expect_next(1'b0, 1'b0, 2'b00, 2'd0, 16'd0);
    tick("rr.rst");
    rst = 1'b0;
    expect_next(1'b0, 1'b0, 2'b00, 2'd0, 16'd0);
    tick("rr.after");
    expect_next(1'b0, 1'b0, 2'b00, 2'd0, 16'd0);
    tick("rr.after2");

    // start and prog_we while busy are ignored.
    start = 1'b1;
    expect_next(1'b1, 1'b0, 2'b11, 2'd0, 16'd0);
    tick("bz.s0");
    prog_we   = 1'b1;
    prog_addr = 2'd1;
    prog_data = E1Alt;
    expect_next(1'b1, 1'b0, 2'b10, 2'd1, 16'd1);
    tick("bz.s1");
    start   = 1'b0;
    prog_we = 1'b0;
    expect_next(1'b0, 1'b1, 2'b00, 2'd0, 16'd2);
    tick("bz.done");
    // start in the done cycle launches a rerun, which must still see the old e1.
    start = 1'b1;
    expect_next(1'b1, 1'b0, 2'b11, 2'd0, 16'd0);
    tick("re.s0");
    start = 1'b0;
    expect_next(1'b1, 1'b0, 2'b10, 2'd1, 16'd1);
    tick("re.s1");
    expect_next(1'b0, 1'b1, 2'b00, 2'd0, 16'd2);
    tick("re.done");
    expect_next(1'b0, 1'b0, 2'b00, 2'd0, 16'd2);
    tick("re.idle");

    // Write and start in the same idle cycle: the run sees the new e0.
    prog(2'd1, E1Alt, 16'd2);
    prog_we   = 1'b1;
    prog_addr = 2'd0;
    prog_data = E0Last;
    start     = 1'b1;
    expect_next(1'b1, 1'b0, 2'b00, 2'd0, 16'd0);
    tick("ws.s0");
    prog_we = 1'b0;
    start   = 1'b0;
    expect_next(1'b0, 1'b1, 2'b00, 2'd0, 16'd1);
    tick("ws.done");
    expect_next(1'b0, 1'b0, 2'b00, 2'd0, 16'd1);
    tick("ws.idle");

    // Self-loop: cycle_cnt saturates and busy stays high.
    prog(2'd0, E0Loop, 16'd1);
    start = 1'b1;
    expect_next(1'b1, 1'b0, 2'b01, 2'd0, 16'd0);
    tick("sl.s0");
    start = 1'b0;
    expect_next(1'b1, 1'b0, 2'b01, 2'd0, 16'd1000);
    repeat (999) @(posedge clk);
    tick("sl.k");
    repeat (64533) @(posedge clk);
    expect_next(1'b1, 1'b0, 2'b01, 2'd0, 16'hFFFE);
    tick("sl.pre");
    expect_next(1'b1, 1'b0, 2'b01, 2'd0, 16'hFFFF);
    tick("sl.sat");
    expect_next(1'b1, 1'b0, 2'b01, 2'd0, 16'hFFFF);
    repeat (3) @(posedge clk);
    tick("sl.hold");
    rst = 1'b1;
    expect_next(1'b0, 1'b0, 2'b00, 2'd0, 16'd0);
    tick("sl.rst");
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
